mem_stage_lsu: RTL

Parametrised memory stage for the 5-stage RV32 pipeline. Sits between EX/MEM and MEM/WB.
- Adds byte/halfword/word loads and stores (funct3-driven sign/zero extension, byte-lane writes) over a configurable-depth word array.
- Adds a configurable access latency with a stall handshake back to the hazard unit.
- Registers the MEM/WB pipeline fields and provides combinational EX forwarding taps.

---
 rtl/mem_stage_lsu.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32 MEM stage: byte/half/word load-store, wait-state stall, MEM/WB regs; optional MEM_MISALIGN_TRAP_EN
module mem_stage_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regwrite_m,
    input  logic [1:0]  result_src_m,
    input  logic        memread_m,
    input  logic        memwrite_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] writedata_m,
    input  logic [4:0]  rd_m,
    input  logic [31:0] pc_plus_4_m,
    output logic        stall_m,
    output logic [31:0] readdata_w,
    output logic        mem_wb_regwrite,
    output logic [1:0]  mem_wb_result_src,
    output logic [31:0] mem_wb_alu_result,
    output logic [31:0] mem_wb_pc_plus_4,
    output logic [4:0]  mem_wb_rd,
    output logic        fwd_regwrite_m,
    output logic [31:0] fwd_alu_result_m
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_w
`endif
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_M1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              access;
    logic              commit;
    logic              misaligned;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_off;
    logic [31:0]       word_rd;
    logic [3:0]        lane_we;
    logic [31:0]       lane_wdata;
    logic [31:0]       readdata_d;

    logic              unused_addr_hi;

    assign access   = memread_m | memwrite_m;
    assign word_idx = alu_result_m[ADDR_W+1:2];
    assign byte_off = alu_result_m[1:0];
    assign word_rd  = mem_q[word_idx];
    assign commit   = ~stall_m;

    assign unused_addr_hi = ^alu_result_m[31:ADDR_W+2];

    assign fwd_regwrite_m   = regwrite_m;
    assign fwd_alu_result_m = alu_result_m;

    // Misaligned halfword/word accesses; without the trap the low bits are simply ignored
    always_comb begin
        misaligned = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (access) begin
            if ((funct3_m == F3_H || funct3_m == F3_HU) && byte_off[0])
                misaligned = 1'b1;
            else if (funct3_m == F3_W && byte_off != 2'b00)
                misaligned = 1'b1;
        end
`endif
    end

    // Stall while an access is starting or still counting down its wait states
    always_comb begin
        stall_m = 1'b0;
        if (WAIT_CYCLES > 0) begin
            if (state_q == S_IDLE)
                stall_m = access;
            else
                stall_m = (cnt_q != 4'd0);
        end
    end

    // Wait-state FSM: IDLE -> BUSY for WAIT_CYCLES-1 further cycles, then commit back in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else if (WAIT_CYCLES > 0) begin
            case (state_q)
                S_IDLE: begin
                    if (access) begin
                        state_q <= S_BUSY;
                        cnt_q   <= WAIT_M1;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Byte-lane enables and lane-replicated store data for the committing store
    always_comb begin
        lane_we    = 4'b0000;
        lane_wdata = 32'd0;
        if (memwrite_m && commit && !misaligned) begin
            case (funct3_m)
                F3_B: begin
                    lane_we    = 4'b0001 << byte_off;
                    lane_wdata = {4{writedata_m[7:0]}};
                end
                F3_H: begin
                    lane_we    = byte_off[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{writedata_m[15:0]}};
                end
                F3_W: begin
                    lane_we    = 4'b1111;
                    lane_wdata = writedata_m;
                end
                default: begin
                    lane_we    = 4'b0000;
                    lane_wdata = 32'd0;
                end
            endcase
        end
    end

    // Data array write; contents survive reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (lane_we[b])
                mem_q[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
        end
    end

    // Extract and extend the addressed byte/half/word from the pre-write word
    always_comb begin
        logic [7:0]  sel_b;
        logic [15:0] sel_h;
        sel_h = byte_off[1] ? word_rd[31:16] : word_rd[15:0];
        case (byte_off)
            2'd0:    sel_b = word_rd[7:0];
            2'd1:    sel_b = word_rd[15:8];
            2'd2:    sel_b = word_rd[23:16];
            default: sel_b = word_rd[31:24];
        endcase
        case (funct3_m)
            F3_B:    readdata_d = {{24{sel_b[7]}}, sel_b};
            F3_BU:   readdata_d = {24'd0, sel_b};
            F3_H:    readdata_d = {{16{sel_h[15]}}, sel_h};
            F3_HU:   readdata_d = {16'd0, sel_h};
            F3_W:    readdata_d = word_rd;
            default: readdata_d = 32'd0;
        endcase
    end

    // MEM/WB register: capture on commit, insert a bubble while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_w        <= 32'd0;
            mem_wb_regwrite   <= 1'b0;
            mem_wb_result_src <= 2'd0;
            mem_wb_alu_result <= 32'd0;
            mem_wb_pc_plus_4  <= 32'd0;
            mem_wb_rd         <= 5'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_w        <= 1'b0;
`endif
        end else if (commit) begin
            readdata_w        <= readdata_d;
            mem_wb_regwrite   <= regwrite_m & ~misaligned;
            mem_wb_result_src <= result_src_m;
            mem_wb_alu_result <= alu_result_m;
            mem_wb_pc_plus_4  <= pc_plus_4_m;
            mem_wb_rd         <= rd_m;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_w        <= misaligned;
`endif
        end else begin
            readdata_w        <= 32'd0;
            mem_wb_regwrite   <= 1'b0;
            mem_wb_result_src <= 2'd0;
            mem_wb_alu_result <= 32'd0;
            mem_wb_pc_plus_4  <= 32'd0;
            mem_wb_rd         <= 5'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_w        <= 1'b0;
`endif
        end
    end

endmodule
